// File: rtl/hub_pkg.sv
// Shared constants and types for the hub slot scheduler.
package hub_pkg;

    localparam int COGS       = 8;
    localparam int SLOT_CLKS  = 2;
    localparam int WAIT_W     = 5;
    localparam int WAIT_LIMIT = 17;

    typedef logic [COGS-1:0]   slot_t;
    typedef logic [WAIT_W-1:0] wait_t;

endpackage

// File: rtl/hub_slot_sched_if.sv
// Hub bus bundle between the cogs (master side) and the slot scheduler (slave side).
interface hub_slot_sched_if
    import hub_pkg::*;
#(
    parameter int N = hub_pkg::COGS
) ();

    logic [N-1:0]         cog_ena;
    logic [N-1:0]         req;
    logic                 ena_bus;
    logic [N-1:0]         bus_sel;
    logic [$clog2(N)-1:0] slot_idx;
    logic                 slot_vld;
    logic                 rot_start;
    logic [N-1:0]         grant;
    logic [N-1:0]         stall;

    modport master (
        output cog_ena, req,
        input  ena_bus, bus_sel, slot_idx, slot_vld, rot_start, grant, stall
    );

    modport slave (
        input  cog_ena, req,
        output ena_bus, bus_sel, slot_idx, slot_vld, rot_start, grant, stall
    );

endinterface

// File: rtl/hub_onehot_enc.sv
// One-hot to binary encoder with a nonzero flag; index is 0 for an all-zero input.
module hub_onehot_enc
    import hub_pkg::*;
#(
    parameter int W     = hub_pkg::COGS,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     onehot_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
        vld_o = |onehot_i;
    end

endmodule

// File: rtl/hub_slot_sched.sv
// Time-division hub slot scheduler: bus phase strobe, one-hot slot rotation, grants and stall monitor.
// Build option HUB_SKIP_IDLE_EN: rotation skips cogs whose cog_ena bit is clear.
module hub_slot_sched
    import hub_pkg::*;
#(
    parameter int COGS       = hub_pkg::COGS,
    parameter int WAIT_LIMIT = hub_pkg::WAIT_LIMIT,
    parameter int WAIT_W     = hub_pkg::WAIT_W
) (
    input  logic            clk_cog,
    input  logic            res,
    hub_slot_sched_if.slave bus
);

    localparam int IDX_W = $clog2(COGS);

    logic                 ena_bus_q, ena_bus_d;
    logic [COGS-1:0]      bus_sel_q, bus_sel_d;
    logic                 rot_start_q, rot_start_d;
    logic [COGS-1:0]      grant_q, grant_d;
    logic [COGS-1:0]      stall_q, stall_d;
    logic [WAIT_W-1:0]    wait_q [COGS];
    logic [WAIT_W-1:0]    wait_d [COGS];

    logic [COGS-1:0]      next_sel;
    logic [COGS-1:0]      first_sel;
    logic [IDX_W-1:0]     slot_idx;
    logic                 slot_vld;

    hub_onehot_enc #(
        .W     (COGS),
        .IDX_W (IDX_W)
    ) u_slot_enc (
        .onehot_i (bus_sel_q),
        .idx_o    (slot_idx),
        .vld_o    (slot_vld)
    );

`ifdef HUB_SKIP_IDLE_EN
    function automatic logic [COGS-1:0] lowest_set(input logic [COGS-1:0] v);
        return v & (~v + COGS'(1));
    endfunction

    // Bits at or below the current slot; an idle bus (0) masks everything so we restart from the bottom.
    logic [COGS-1:0] at_or_below;
    logic [COGS-1:0] above;

    assign at_or_below = (bus_sel_q << 1) - COGS'(1);
    assign above       = bus.cog_ena & ~at_or_below;
    assign next_sel    = (|above) ? lowest_set(above) : lowest_set(bus.cog_ena);
    assign first_sel   = lowest_set(bus.cog_ena);
`else
    assign next_sel    = {bus_sel_q[COGS-2:0], ~|bus_sel_q[COGS-2:0]};
    assign first_sel   = COGS'(1);
`endif

    always_comb begin
        ena_bus_d   = ~ena_bus_q;
        bus_sel_d   = bus_sel_q;
        rot_start_d = 1'b0;
        grant_d     = '0;
        stall_d     = stall_q;
        for (int i = 0; i < COGS; i++) begin
            wait_d[i] = '0;
        end

        // Slot hand-off happens on the high bus phase; the grant lands with it.
        if (ena_bus_q) begin
            bus_sel_d   = next_sel;
            rot_start_d = (|next_sel) && (next_sel == first_sel);
            grant_d     = bus_sel_q & bus.req & bus.cog_ena;
        end

        for (int i = 0; i < COGS; i++) begin
            if (bus.req[i] && bus.cog_ena[i] && !grant_q[i]) begin
                wait_d[i] = (&wait_q[i]) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
            end
            if (wait_d[i] >= WAIT_W'(WAIT_LIMIT)) begin
                stall_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_cog) begin
        if (res) begin
            ena_bus_q   <= 1'b0;
            bus_sel_q   <= '0;
            rot_start_q <= 1'b0;
            grant_q     <= '0;
            stall_q     <= '0;
            for (int i = 0; i < COGS; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            ena_bus_q   <= ena_bus_d;
            bus_sel_q   <= bus_sel_d;
            rot_start_q <= rot_start_d;
            grant_q     <= grant_d;
            stall_q     <= stall_d;
            for (int i = 0; i < COGS; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign bus.ena_bus   = ena_bus_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.slot_idx  = slot_idx;
    assign bus.slot_vld  = slot_vld;
    assign bus.rot_start = rot_start_q;
    assign bus.grant     = grant_q;
    assign bus.stall     = stall_q;

endmodule

// File: tb/tb_hub_slot_sched.sv
// Bench for hub_slot_sched: a default instance and a WAIT_LIMIT=4 instance share stimulus and are
// compared every cycle against a model derived from elapsed time since reset.
`timescale 1ns/1ps
module tb_hub_slot_sched;
    import hub_pkg::*;

    localparam int N   = COGS;
    localparam int SAT = (1 << WAIT_W) - 1;

    logic  clk_cog = 1'b0;
    logic  res     = 1'b1;
    slot_t req     = '0;
    slot_t cog_ena = '1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int    m_t;
    slot_t m_sel, m_grant, m_stall, m_stall4;
    logic  m_rot;
    int    m_cnt [N];

    always #5 clk_cog = ~clk_cog;

    hub_slot_sched_if ifa ();
    hub_slot_sched_if ifb ();

    assign ifa.req     = req;
    assign ifa.cog_ena = cog_ena;
    assign ifb.req     = req;
    assign ifb.cog_ena = cog_ena;

    hub_slot_sched #(.COGS(N), .WAIT_LIMIT(WAIT_LIMIT), .WAIT_W(WAIT_W)) dut (
        .clk_cog (clk_cog),
        .res     (res),
        .bus     (ifa)
    );

    hub_slot_sched #(.COGS(N), .WAIT_LIMIT(4), .WAIT_W(WAIT_W)) dut4 (
        .clk_cog (clk_cog),
        .res     (res),
        .bus     (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, m_t);
        end
    endtask

    function automatic int exp_idx(input slot_t s);
        int r = 0;
        for (int i = 0; i < N; i++) if (s[i]) r = i;
        return r;
    endfunction

    // Circular search upward from the current slot, wrapping through it, for the next enabled cog.
    function automatic slot_t next_enabled(input slot_t cur, input slot_t en);
        int    base = -1;
        slot_t r    = '0;
        for (int i = 0; i < N; i++) if (cur[i]) base = i;
        for (int k = N; k >= 1; k--) begin
            int j = (base + k + N) % N;
            if (en[j]) r = slot_t'(1) << j;
        end
        return r;
    endfunction

    function automatic slot_t lowest_enabled(input slot_t en);
        slot_t r = '0;
        for (int i = N - 1; i >= 0; i--) if (en[i]) r = slot_t'(1) << i;
        return r;
    endfunction

    task automatic tick();
        slot_t n_sel, n_grant, n_stall, n_stall4;
        logic  n_rot;
        int    n_t;
        int    n_cnt [N];
        logic  adv;
        adv      = (m_t % 2) == 1;
        n_t      = res ? 0 : m_t + 1;
        n_sel    = '0;
        n_rot    = 1'b0;
        n_grant  = '0;
        n_stall  = '0;
        n_stall4 = '0;
        for (int i = 0; i < N; i++) n_cnt[i] = 0;
        if (!res) begin
`ifdef HUB_SKIP_IDLE_EN
            n_sel = adv ? next_enabled(m_sel, cog_ena) : m_sel;
            n_rot = adv && (n_sel != '0) && (n_sel == lowest_enabled(cog_ena));
`else
            if (n_t >= 2) n_sel = slot_t'(1) << (((n_t - 2) / SLOT_CLKS) % N);
            n_rot = (n_t >= 2) && (((n_t - 2) % (SLOT_CLKS * N)) == 0);
`endif
            for (int i = 0; i < N; i++) begin
                n_grant[i] = adv && m_sel[i] && req[i] && cog_ena[i];
                if (req[i] && cog_ena[i] && !m_grant[i])
                    n_cnt[i] = (m_cnt[i] < SAT) ? m_cnt[i] + 1 : SAT;
                n_stall[i]  = m_stall[i]  || (n_cnt[i] >= WAIT_LIMIT);
                n_stall4[i] = m_stall4[i] || (n_cnt[i] >= 4);
            end
        end
        @(posedge clk_cog);
        #1;
        m_t      = n_t;
        m_sel    = n_sel;
        m_rot    = n_rot;
        m_grant  = n_grant;
        m_stall  = n_stall;
        m_stall4 = n_stall4;
        for (int i = 0; i < N; i++) m_cnt[i] = n_cnt[i];
        chk("ena_bus",   ifa.ena_bus,   (m_t % 2) == 1);
        chk("bus_sel",   ifa.bus_sel,   m_sel);
        chk("slot_idx",  ifa.slot_idx,  exp_idx(m_sel));
        chk("slot_vld",  ifa.slot_vld,  m_sel != '0);
        chk("rot_start", ifa.rot_start, m_rot);
        chk("grant",     ifa.grant,     m_grant);
        chk("stall",     ifa.stall,     m_stall);
        chk("grant_l4",  ifb.grant,     m_grant);
        chk("stall_l4",  ifb.stall,     m_stall4);
    endtask

    // Requesters drop req in the cycle they see their grant; optionally raise new requests.
    task automatic react(input bit rnd);
        req = req & ~m_grant;
        if (rnd) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && !m_grant[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
        end
    endtask

    initial begin
        m_t = 0; m_sel = '0; m_grant = '0; m_stall = '0; m_stall4 = '0; m_rot = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset values, then the bare rotation with no requests.
        res = 1'b1; req = '0; cog_ena = 8'hFF;
        tick();
        tick();
        res = 1'b0;
        repeat (20) begin
            tick();
            if (m_t == 2 || m_t == 18) chk("rot_c2_c18", ifa.bus_sel, 8'h01);
            if (m_t == 16) chk("sel_c16", ifa.bus_sel, 8'h80);
        end

        // Directed requests: cog 3 early in its wait, cog 2 just after its slot.
        res = 1'b1;
        tick();
        res = 1'b0;
        while (m_t < 40) begin
            if (m_t == 5) req[3] = 1'b1;
            if (m_t == 8) req[2] = 1'b1;
            tick();
            react(1'b0);
            if (m_t == 10) chk("grant_c10", ifa.grant, 8'h08);
            if (m_t == 24) begin
                chk("grant_c24",  ifa.grant,    8'h04);
                chk("stall2_c24", ifa.stall[2], 1'b0);
                chk("stall2_l4",  ifb.stall[2], 1'b1);
            end
        end

        // Disabled cog with its request held.
        cog_ena = 8'hDF;
        req[5]  = 1'b1;
        repeat (64) begin
            tick();
            react(1'b0);
            chk("grant5_off", ifa.grant[5], 1'b0);
        end
        req[5]  = 1'b0;
        cog_ena = 8'hFF;

        // Randomized traffic with occasional cog_ena changes.
        repeat (600) begin
            if ($urandom_range(0, 15) == 0)
                cog_ena = ($urandom_range(0, 2) == 0) ? slot_t'($urandom) : 8'hFF;
            tick();
            react(1'b1);
        end

        // One reset edge mid-rotation with requests in flight.
        cog_ena = 8'hFF;
        repeat (7) begin
            tick();
            react(1'b1);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        chk("rst_sel",    ifa.bus_sel, 8'h00);
        chk("rst_stall4", ifb.stall,   8'h00);
        repeat (40) begin
            tick();
            react(1'b1);
        end

        // Sparse enable pattern, then everything disabled.
        req     = '0;
        cog_ena = 8'h11;
        repeat (20) begin
            tick();
            react(1'b0);
        end
        cog_ena = 8'h00;
        repeat (10) begin
            tick();
            react(1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
